// File: rtl/mem_arbiter_nch.sv
// rtl/mem_arbiter_nch.sv - N-channel single-outstanding RAM arbiter (optional MEM_ARB_ROUND_ROBIN_EN)
module mem_arbiter_nch #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     nRst,
    input  logic [NUM_CH-1:0]        ch_ren,
    input  logic [NUM_CH-1:0]        ch_wen,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_store,
    output logic [NUM_CH-1:0]        ch_ready,
    output logic [DATA_W-1:0]        load_o,
    output logic                     Ren,
    output logic                     Wen,
    output logic [ADDR_W-1:0]        ramaddr,
    output logic [DATA_W-1:0]        ramstore,
    input  logic [DATA_W-1:0]        ramload,
    input  logic                     busy_o
);

    localparam int GW = $clog2(NUM_CH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t              state;
    state_t              state_nx;
    logic [GW-1:0]       grant_q;
    logic [GW-1:0]       winner;
    logic                win_valid;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   store_q;
    logic                op_wr_q;
    logic [NUM_CH-1:0]   req;
    logic [ADDR_W-1:0]   addr_arr  [NUM_CH];
    logic [DATA_W-1:0]   store_arr [NUM_CH];
    logic                ram_done;

    assign req      = ch_ren | ch_wen;
    assign ram_done = (state == WAIT) && !busy_o;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign addr_arr[g]  = ch_addr[g*ADDR_W +: ADDR_W];
        assign store_arr[g] = ch_store[g*DATA_W +: DATA_W];
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [GW-1:0] rr_ptr;
    int            idx;

    // Round-robin winner: first requester at or above the pointer, wrapping around.
    always_comb begin
        winner    = '0;
        win_valid = 1'b0;
        idx       = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (req[GW'(idx)]) begin
                winner    = GW'(idx);
                win_valid = 1'b1;
            end
        end
    end

    // Pointer moves past the served channel as the transaction completes.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rr_ptr <= '0;
        end else if (ram_done) begin
            rr_ptr <= (grant_q == GW'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
        end
    end
`else
    // Fixed priority winner: the lowest requesting index.
    always_comb begin
        winner    = '0;
        win_valid = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[GW'(i)]) begin
                winner    = GW'(i);
                win_valid = 1'b1;
            end
        end
    end
`endif

    // Next-state logic; REQ always advances, WAIT holds while the RAM is busy.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (win_valid) state_nx = REQ;
            REQ:     state_nx = WAIT;
            WAIT:    if (!busy_o) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register, request latches and captured load data.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state   <= IDLE;
            grant_q <= '0;
            addr_q  <= '0;
            store_q <= '0;
            op_wr_q <= 1'b0;
            load_o  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && win_valid) begin
                grant_q <= winner;
                addr_q  <= addr_arr[winner];
                store_q <= store_arr[winner];
                op_wr_q <= ch_wen[winner];
            end
            if (ram_done && !op_wr_q) begin
                load_o <= ramload;
            end
        end
    end

    // RAM side driven purely from state and latches, so requesters never reach it combinationally.
    always_comb begin
        Ren      = ((state == REQ) || (state == WAIT)) && !op_wr_q;
        Wen      = ((state == REQ) || (state == WAIT)) && op_wr_q;
        ramaddr  = addr_q;
        ramstore = store_q;
        ch_ready = '0;
        if (state == DONE) begin
            ch_ready[grant_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter_nch.sv
// tb/tb_mem_arbiter_nch.sv - scoreboard bench for mem_arbiter_nch (NUM_CH=4)
module tb_mem_arbiter_nch;

    localparam int NCH = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;

    logic              clk = 1'b0;
    logic              nRst;
    logic [NCH-1:0]    ch_ren;
    logic [NCH-1:0]    ch_wen;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*DW-1:0] ch_store;
    logic [NCH-1:0]    ch_ready;
    logic [DW-1:0]     load_o;
    logic              Ren;
    logic              Wen;
    logic [AW-1:0]     ramaddr;
    logic [DW-1:0]     ramstore;
    logic [DW-1:0]     ramload;
    logic              busy_o;

    int nb = 0;
    int act_cnt = 0;
    int cyc = 0;
    int ren_cnt = 0;
    int wen_cnt = 0;
    int both_cnt = 0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_store = '0;
    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [NCH-1:0] rdy;
        logic [DW-1:0]  load;
    } exp_t;
    exp_t sbq[$];

    mem_arbiter_nch #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .nRst(nRst), .ch_ren(ch_ren), .ch_wen(ch_wen),
        .ch_addr(ch_addr), .ch_store(ch_store), .ch_ready(ch_ready),
        .load_o(load_o), .Ren(Ren), .Wen(Wen), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // RAM model: busy for nb WAIT cycles, fixed data pattern from the address.
    assign busy_o  = (Ren | Wen) && (act_cnt >= 1) && (act_cnt <= nb);
    assign ramload = (ramaddr == 32'h100) ? 32'hDEADBEEF : {16'hA5A5, ramaddr[15:0]};

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        act_cnt <= (Ren | Wen) ? act_cnt + 1 : 0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: activity counters plus scoreboard pop on every ready pulse.
    always @(negedge clk) begin
        if (Ren) ren_cnt++;
        if (Wen) wen_cnt++;
        if (Ren && Wen) both_cnt++;
        if (Ren || Wen) begin
            last_addr  = ramaddr;
            last_store = ramstore;
        end
        if (nRst && |ch_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_ready", 64'(ch_ready), 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("sb_ready", 64'(ch_ready), 64'(e.rdy));
                check("sb_load", 64'(load_o), 64'(e.load));
            end
        end
    end

    task automatic push(input logic [NCH-1:0] r, input logic [DW-1:0] l);
        exp_t e;
        e.rdy  = r;
        e.load = l;
        sbq.push_back(e);
    endtask

    task automatic wait_ready(output int at_cyc, output logic [NCH-1:0] seen);
        at_cyc = -1;
        seen   = '0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (|ch_ready) begin
                at_cyc = cyc;
                seen   = ch_ready;
                return;
            end
        end
        check("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        nRst = 1'b0;
        repeat (2) @(negedge clk);
        nRst = 1'b1;
    endtask

    int c0, at, r0, w0;
    logic [NCH-1:0] seen;
    logic [NCH-1:0] rr_exp [4];

    initial begin
        nRst = 1'b0; ch_ren = '0; ch_wen = '0; ch_addr = '0; ch_store = '0;
        repeat (2) @(negedge clk);
        check("rst_ren", 64'(Ren), 64'd0);
        check("rst_wen", 64'(Wen), 64'd0);
        check("rst_ready", 64'(ch_ready), 64'd0);
        check("rst_load", 64'(load_o), 64'd0);
        check("rst_addr", 64'(ramaddr), 64'd0);
        check("rst_store", 64'(ramstore), 64'd0);
        nRst = 1'b1;
        @(negedge clk);

        // Single read on channel 1 with two busy cycles.
        nb = 2; c0 = cyc; r0 = ren_cnt;
        ch_addr[1*AW +: AW] = 32'h100;
        ch_ren = 4'b0010;
        push(4'b0010, 32'hDEADBEEF);
        wait_ready(at, seen);
        ch_ren = '0;
        check("rd_latency", 64'(at - c0), 64'd5);
        check("rd_ren_cycles", 64'(ren_cnt - r0), 64'd4);
        check("rd_ramaddr", 64'(last_addr), 64'h100);
        repeat (2) @(negedge clk);

        // Zero-wait write on channel 0; load_o must keep the previous read data.
        nb = 0; c0 = cyc; w0 = wen_cnt;
        ch_addr[0 +: AW] = 32'h40;
        ch_store[0 +: DW] = 32'h1234;
        ch_wen = 4'b0001;
        push(4'b0001, 32'hDEADBEEF);
        wait_ready(at, seen);
        ch_wen = '0;
        check("wr_latency", 64'(at - c0), 64'd3);
        check("wr_wen_cycles", 64'(wen_cnt - w0), 64'd2);
        check("wr_ramstore", 64'(last_store), 64'h1234);
        check("wr_ramaddr", 64'(last_addr), 64'h40);
        repeat (2) @(negedge clk);

        // Read+write on channel 1, then address change and withdrawal during WAIT.
        nb = 2; r0 = ren_cnt; w0 = wen_cnt;
        ch_addr[1*AW +: AW] = 32'h300;
        ch_store[1*DW +: DW] = 32'h777;
        ch_ren = 4'b0010; ch_wen = 4'b0010;
        push(4'b0010, 32'hDEADBEEF);
        repeat (2) @(negedge clk);
        ch_addr[1*AW +: AW] = 32'h999;
        ch_ren = '0; ch_wen = '0;
        wait_ready(at, seen);
        check("both_ren_cycles", 64'(ren_cnt - r0), 64'd0);
        check("both_wen_cycles", 64'(wen_cnt - w0), 64'd4);
        check("both_ramaddr_held", 64'(last_addr), 64'h300);
        check("both_ramstore", 64'(last_store), 64'h777);
        repeat (2) @(negedge clk);

        // Reset while the RAM is busy; the still-pending request is re-granted afterwards.
        nb = 10;
        ch_addr[2*AW +: AW] = 32'h20;
        ch_ren = 4'b0100;
        repeat (3) @(negedge clk);
        nRst = 1'b0;
        #1;
        check("rstw_ren", 64'(Ren), 64'd0);
        check("rstw_wen", 64'(Wen), 64'd0);
        check("rstw_ready", 64'(ch_ready), 64'd0);
        check("rstw_load", 64'(load_o), 64'd0);
        nb = 0;
        repeat (2) @(negedge clk);
        nRst = 1'b1;
        push(4'b0100, 32'hA5A50020);
        wait_ready(at, seen);
        ch_ren = '0;
        repeat (2) @(negedge clk);

        // All four channels contend; each drops after its ready.
        do_reset();
        nb = 1;
        for (int i = 0; i < NCH; i++) ch_addr[i*AW +: AW] = 32'h10 + 32'(4 * i);
        push(4'b0001, 32'hA5A50010);
        push(4'b0010, 32'hA5A50014);
        push(4'b0100, 32'hA5A50018);
        push(4'b1000, 32'hA5A5001C);
        ch_ren = 4'b1111;
        for (int k = 0; k < NCH; k++) begin
            wait_ready(at, seen);
            ch_ren = ch_ren & ~seen;
        end
        repeat (2) @(negedge clk);

        // Channels 0 and 2 keep requesting after every ready.
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr_exp = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
`else
        rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        ch_addr[0 +: AW] = 32'h30;
        ch_addr[2*AW +: AW] = 32'h38;
        for (int k = 0; k < 4; k++) push(rr_exp[k], rr_exp[k][0] ? 32'hA5A50030 : 32'hA5A50038);
        ch_ren = 4'b0101;
        for (int k = 0; k < 4; k++) wait_ready(at, seen);
        ch_ren = '0;
        repeat (6) @(negedge clk);

        check("sb_empty", 64'(sbq.size()), 64'd0);
        check("never_both", 64'(both_cnt), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter_nch.md
Name: mem_arbiter_nch

Overview:
- Parametrised successor to the two-port (instruction/data) memory controller.
- Arbitrates NUM_CH requester channels onto a single RAM port; each channel issues read or write requests.
- Only one RAM transaction is outstanding at a time; the grant is held for the whole transaction.
- The requester receives a one-cycle ready pulse with registered load data. Sits between the request unit / caches and the RAM model.

Parameters:
- NUM_CH, 2, number of requester channels; legal range 2..8. Channel 0 has highest fixed priority.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  input  1  system clock.
- nRst  input  1  asynchronous active-low reset.
- ch_ren  input  NUM_CH  per-channel read request; held until that channel's ready pulse.
- ch_wen  input  NUM_CH  per-channel write request; held until that channel's ready pulse.
- ch_addr  input  NUM_CH*ADDR_W  packed addresses; channel i occupies [i*ADDR_W +: ADDR_W].
- ch_store  input  NUM_CH*DATA_W  packed write data; same packing as ch_addr.
- ch_ready  output  NUM_CH  one-hot, one-cycle completion pulse.
- load_o  output  DATA_W  read data; valid when any ch_ready is high; held until the next completion.
- Ren  output  1  RAM read enable.
- Wen  output  1  RAM write enable.
- ramaddr  output  ADDR_W  RAM address.
- ramstore  output  DATA_W  RAM write data.
- ramload  input  DATA_W  RAM read data.
- busy_o  input  1  RAM busy; high while the RAM is processing.

Behaviour:
- Reset (async, nRst=0), regardless of state, including mid-transaction:
  - state=IDLE;
  - all outputs 0;
  - grant register 0;
  - round-robin pointer 0.
  - Any in-flight transaction is abandoned with no ready pulse.
- A channel is requesting when ch_ren[i] | ch_wen[i]. If both are high, the transaction is a write.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If no channel is requesting, stay in IDLE.
  - Otherwise select the winner (fixed priority: lowest index wins) and register grant, addr, store and op.
  - Go to REQ.
- REQ:
  - Drive Ren or Wen from the latched op, with ramaddr/ramstore from the latches.
  - Go to WAIT unconditionally.
- WAIT:
  - Keep driving Ren/Wen, ramaddr and ramstore.
  - If busy_o=1, stay in WAIT.
  - If busy_o=0: capture ramload into load_o (reads only; writes leave load_o unchanged) and go to DONE.
  - The RAM must raise busy_o no later than the first WAIT cycle. A single-cycle RAM keeps busy_o low.
- DONE:
  - Ren=Wen=0; ch_ready[grant]=1 for exactly this cycle.
  - Go to IDLE.
  - The requester drops its request on the edge where it sees ready, so IDLE does not re-grant the same request.
- Timing:
  - Minimum latency is request seen in IDLE at cycle t, ready at t+3.
  - Each extra busy cycle adds one cycle.
  - Back-to-back requests from one channel achieve one transaction per 4 cycles.
- Request changes while granted:
  - Changes to ch_addr/ch_store/ch_ren/ch_wen of the granted channel after grant are ignored; latched values are used.
  - A request withdrawn mid-transaction still completes and still pulses ready.
- Ren and Wen are never both 1. All outputs are registered or driven from state plus latches; there is no combinational path from ch_* to the RAM ports.
- busy_o high while in IDLE is ignored.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - The rr pointer holds the index after the last granted channel.
  - The IDLE winner is the first requesting channel searching from the pointer upward with wrap-around.
  - The pointer updates to (grant+1) mod NUM_CH on entry to DONE.
- Not defined: fixed priority (lowest index wins); no pointer register exists.

Test Plan:
- Single read: ch_ren=2'b10, ch_addr[1]=0x100, busy_o high 2 cycles in WAIT, ramload=0xDEADBEEF -> Ren high for REQ plus 3 WAIT cycles, ramaddr=0x100, ch_ready=2'b10 at t+5, load_o=0xDEADBEEF.
- Write, zero-wait: ch_wen=2'b01, addr=0x40, store=0x1234, busy_o=0 -> Wen high 2 cycles, ramstore=0x1234, ch_ready=2'b01 at t+3, load_o unchanged.
- Contention, fixed priority, NUM_CH=4: all channels request continuously and each drops after its ready -> service order 0,1,2,3.
- Contention, MEM_ARB_ROUND_ROBIN_EN, NUM_CH=4: channels 0 and 2 re-request immediately after each ready -> grants alternate 0,2,0,2; no starvation of 2.
- Reset in WAIT: nRst=0 while busy_o=1 -> Ren/Wen/ch_ready/load_o=0 immediately. After release, the pending request is re-granted from IDLE.
- Both ren and wen on channel 1, plus addr change during WAIT -> Wen only; ramaddr stays the originally latched value.
